uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clock cycles per serial bit; legal range 4..127.
REQ-002 SHALL have parameter BITS, default 8, meaning data bits per frame; legal range 5..8.
REQ-003 SHALL have port i_wb_clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-004 SHALL have port i_wb_rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port i_rx  input  1  asynchronous serial line; idle high, 8-N-1 style, LSB first.
REQ-006 SHALL have port o_data  output  BITS  last correctly framed received word.
REQ-007 SHALL have port o_valid  output  1  one-cycle pulse; o_data updated this cycle.
REQ-008 SHALL have port o_frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL pass i_rx through a 2-flop synchronizer (both flops reset to 1); rx_s denotes the second flop output; no other logic reads i_rx.
REQ-011 SHALL implement states IDLE, START, DATA, STOP with a 7-bit cycle counter cnt and a 3-bit bit index idx.
REQ-012 IDLE: cnt=0, idx=0; when rx_s==0 -> START next cycle; otherwise stay.
REQ-013 START: cnt increments each cycle; when cnt==(CLKS_PER_BIT-1)/2 (integer division), sample rx_s: if 0 -> DATA with cnt=0; if 1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: cnt increments; when cnt==CLKS_PER_BIT-1, shift register bit idx <= rx_s, cnt=0; if idx==BITS-1 -> STOP with idx=0, else idx+1.
REQ-015 Each data sample SHALL therefore fall a whole number of bit periods after the mid-start sample, i.e. mid-bit.
REQ-016 STOP: cnt increments; when cnt==CLKS_PER_BIT-1, sample rx_s: if 1 -> o_data <= shift register, o_valid=1 next cycle; if 0 -> o_frame_err=1 next cycle, o_data unchanged; both cases -> IDLE, cnt=0.
REQ-017 Return to IDLE SHALL happen at mid-stop-bit, so a start bit immediately following the stop bit is detected without frame loss.
REQ-018 o_valid and o_frame_err SHALL each be high for exactly one cycle per frame and never together.
REQ-019 Latency: o_valid rises exactly (CLKS_PER_BIT-1)/2 + 1 + (BITS+1)*CLKS_PER_BIT + 1 cycles after the first cycle rx_s is 0 in IDLE.
REQ-020 No input handshake: a new frame overwrites o_data regardless of consumer; consumer must capture on o_valid.
REQ-021 Line held low (break) SHALL produce one o_frame_err, then remain in IDLE->START cycles only after rx_s returns high and falls again... precisely: after IDLE is reentered with rx_s==0, a new START begins immediately; each 0-frame yields data 0 + o_frame_err.
REQ-022 Undefined state encodings SHALL go to IDLE next cycle.

Reset
REQ-023 i_wb_rst_n==0 at a rising edge SHALL set state=IDLE, cnt=0, idx=0, shift register=0, o_data=0, o_valid=0, o_frame_err=0, o_busy=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no o_valid/o_frame_err pulse; reception resumes on the next falling edge after release.
REQ-025 Reset SHALL take priority over all state transitions in the same cycle.

Verification (CLKS_PER_BIT=16, BITS=8 unless stated)
REQ-026 Send 0xA5 framed correctly -> one o_valid pulse, o_data=0xA5, o_frame_err never high, o_busy low after pulse.
REQ-027 Send 0x3C then 0xC3 back-to-back (no idle between stop and start) -> two o_valid pulses, o_data 0x3C then 0xC3.
REQ-028 Low glitch of 5 cycles on idle line -> returns to IDLE, no pulse on o_valid or o_frame_err.
REQ-029 Send 0x55 with stop bit driven 0 -> one o_frame_err pulse, o_data keeps previous value, no o_valid.
REQ-030 Assert i_wb_rst_n=0 for 1 cycle during data bit 4 of 0xFF, then send 0x12 -> no pulse for aborted frame, o_data=0x12 after valid.
REQ-031 Default parameters (CLKS_PER_BIT=104), send 0x81 -> o_valid at exactly the REQ-019 cycle count, o_data=0x81.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: a 2-flop synchronizer feeds a START/DATA/STOP sampler.
// Each frame ends in either a one-cycle o_valid with its data word or a one-cycle o_frame_err.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int BITS         = 8
) (
  input  logic            i_wb_clk,
  input  logic            i_wb_rst_n,
  input  logic            i_rx,
  output logic [BITS-1:0] o_data,
  output logic            o_valid,
  output logic            o_frame_err,
  output logic            o_busy
);

  localparam logic [6:0] MID_CNT  = 7'((CLKS_PER_BIT - 1) / 2);
  localparam logic [6:0] LAST_CNT = 7'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_IDX = 3'(BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
  } state_t;

  logic            sync1_reg;
  logic            sync2_reg;
  logic            rx_s;
  state_t          state_reg;
  state_t          state_next;
  logic [6:0]      cnt_reg;
  logic [6:0]      cnt_next;
  logic [2:0]      idx_reg;
  logic [2:0]      idx_next;
  logic [BITS-1:0] shift_reg;
  logic [BITS-1:0] shift_next;
  logic [BITS-1:0] data_reg;
  logic [BITS-1:0] data_next;
  logic            valid_reg;
  logic            valid_next;
  logic            frame_err_reg;
  logic            frame_err_next;
  logic            bit_sample;
  logic            stop_sample;

  assign rx_s = sync2_reg;

  // State register: all storage, including the synchronizer, lives here.
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      sync1_reg     <= 1'b1;
      sync2_reg     <= 1'b1;
      state_reg     <= S_IDLE;
      cnt_reg       <= 7'd0;
      idx_reg       <= 3'd0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      sync1_reg     <= i_rx;
      sync2_reg     <= sync1_reg;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Next-state logic. The start bit is checked at its midpoint and every later
  // sample is a whole bit period after that, so data and stop are read mid-bit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    bit_sample = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cnt_next = 7'd0;
        idx_next = 3'd0;
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        if (cnt_reg == MID_CNT) begin
          cnt_next   = 7'd0;
          state_next = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_next = cnt_reg + 7'd1;
        end
      end
      S_DATA: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = 7'd0;
          bit_sample = 1'b1;
          if (idx_reg == LAST_IDX) begin
            idx_next   = 3'd0;
            state_next = S_STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 7'd1;
        end
      end
      // Leaving at mid-stop-bit gives half a bit of slack to catch the next start edge.
      S_STOP: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = 7'd0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 7'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 7'd0;
        idx_next   = 3'd0;
      end
    endcase
  end

  // Each data sample lands directly in its bit position; idle bits hold.
  generate
    for (genvar gi = 0; gi < BITS; gi++) begin : g_shift
      assign shift_next[gi] = (bit_sample && (idx_reg == 3'(gi))) ? rx_s : shift_reg[gi];
    end
  endgenerate

  // Output logic: the stop-bit sample decides between a good word and a framing error.
  always_comb begin
    stop_sample    = (state_reg == S_STOP) && (cnt_reg == LAST_CNT);
    valid_next     = stop_sample && rx_s;
    frame_err_next = stop_sample && !rx_s;
    data_next      = valid_next ? shift_reg : data_reg;
    o_busy         = (state_reg != S_IDLE);
  end

  assign o_data      = data_reg;
  assign o_valid     = valid_reg;
  assign o_frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, checked against an
// event list predicted from frame timing arithmetic (start edge + fixed latency).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int CPB_DEF = 104;
  localparam int LAT     = (CPB - 1) / 2 + 2 + 9 * CPB;
  localparam int LAT_DEF = (CPB_DEF - 1) / 2 + 2 + 9 * CPB_DEF;
  localparam int BRK_LEN = 310;

  logic       clk = 1'b0;
  logic       rst_n, rx, rst2_n, rx2;
  logic [7:0] o_data, o_data2;
  logic       o_valid, o_frame_err, o_busy;
  logic       o_valid2, o_frame_err2, o_busy2;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .BITS(8)) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_rx(rx),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  uart_rx dut_def (
    .i_wb_clk(clk), .i_wb_rst_n(rst2_n), .i_rx(rx2),
    .o_data(o_data2), .o_valid(o_valid2), .o_frame_err(o_frame_err2), .o_busy(o_busy2)
  );

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  ev_t        obs2_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;
  bit         both_seen = 1'b0;
  logic [7:0] last_good;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid)     obs_q.push_back(ev_t'{cyc, 1'b0, o_data});
    if (o_frame_err) obs_q.push_back(ev_t'{cyc, 1'b1, o_data});
    if (o_valid && o_frame_err) both_seen = 1'b1;
    if (o_valid2 || o_frame_err2) obs2_q.push_back(ev_t'{cyc, o_frame_err2, o_data2});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx2 = v;
    else     rx  = v;
  endtask

  task automatic idle(input bit sel, input int n);
    repeat (n) begin
      tick();
      drive(sel, 1'b1);
    end
  endtask

  task automatic hold_low(input int n, output int c0);
    for (int k = 0; k < n; k++) begin
      tick();
      rx = 1'b0;
      if (k == 0) c0 = cyc;
    end
    rx = 1'b1;
  endtask

  // One 10-bit frame; rst_bit selects a frame bit during which reset pulses for one cycle.
  task automatic send_frame(input bit sel, input int cpb, input logic [7:0] d,
                            input logic stop, input int rst_bit, output int c0);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < cpb; k++) begin
        tick();
        drive(sel, fr[b]);
        if (!sel) rst_n = !((b == rst_bit) && (k == cpb / 2));
        if ((b == 0) && (k == 0)) c0 = cyc;
      end
    end
    if (!sel) rst_n = 1'b1;
  endtask

  // Reference: rx_s goes low two cycles after the driven edge; the pulse follows LAT later.
  task automatic expect_frame(input int c0, input logic [7:0] d, input logic stop);
    if (stop) begin
      exp_q.push_back(ev_t'{c0 + 2 + LAT, 1'b0, d});
      last_good = d;
    end else begin
      exp_q.push_back(ev_t'{c0 + 2 + LAT, 1'b1, last_good});
    end
  endtask

  task automatic check_events(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_%0d_cycle", tag, i), obs_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s_%0d_kind", tag, i), {31'd0, obs_q[i].err}, {31'd0, exp_q[i].err});
      chk($sformatf("%s_%0d_data", tag, i), {24'd0, obs_q[i].data}, {24'd0, exp_q[i].data});
      $display("event %s[%0d]: cycle=%0d err=%0b data=%02h", tag, i,
               obs_q[i].cyc, obs_q[i].err, obs_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int         c0;
    int         r;
    logic [7:0] d;

    rst_n = 1'b0; rst2_n = 1'b0; rx = 1'b1; rx2 = 1'b1;
    repeat (3) tick();
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, o_frame_err}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_def_busy", {31'd0, o_busy2}, 32'd0);
    rst_n = 1'b1; rst2_n = 1'b1;
    last_good = 8'h00;
    idle(1'b0, 5);
    obs_q.delete();

    send_frame(1'b0, CPB, 8'hA5, 1'b1, -1, c0);
    expect_frame(c0, 8'hA5, 1'b1);
    idle(1'b0, 40);
    check_events("a5");
    chk("a5_busy_after", {31'd0, o_busy}, 32'd0);

    send_frame(1'b0, CPB, 8'h3C, 1'b1, -1, c0);
    expect_frame(c0, 8'h3C, 1'b1);
    send_frame(1'b0, CPB, 8'hC3, 1'b1, -1, c0);
    expect_frame(c0, 8'hC3, 1'b1);
    idle(1'b0, 40);
    check_events("b2b");

    hold_low(5, c0);
    idle(1'b0, 40);
    check_events("glitch");
    chk("glitch_busy", {31'd0, o_busy}, 32'd0);

    send_frame(1'b0, CPB, 8'h55, 1'b0, -1, c0);
    expect_frame(c0, 8'h55, 1'b0);
    idle(1'b0, 40);
    check_events("ferr");
    chk("ferr_data_kept", {24'd0, o_data}, {24'd0, last_good});

    // Break: every complete all-low frame inside the low window is a framing error.
    hold_low(BRK_LEN, c0);
    for (int s = 0; s + LAT - 1 < BRK_LEN; s += LAT)
      exp_q.push_back(ev_t'{c0 + 2 + s + LAT, 1'b1, last_good});
    idle(1'b0, 60);
    check_events("break");

    send_frame(1'b0, CPB, 8'hFF, 1'b1, 5, c0);
    last_good = 8'h00;
    idle(1'b0, 5);
    chk("abort_data_cleared", {24'd0, o_data}, 32'd0);
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    send_frame(1'b0, CPB, 8'h12, 1'b1, -1, c0);
    expect_frame(c0, 8'h12, 1'b1);
    idle(1'b0, 40);
    check_events("abort");
    chk("abort_data_12", {24'd0, o_data}, 32'h12);

    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(0, 9);
      d = 8'($urandom);
      if (r < 2) begin
        hold_low($urandom_range(1, 7), c0);
        idle(1'b0, 40);
      end else if (r < 4) begin
        send_frame(1'b0, CPB, d, 1'b0, -1, c0);
        expect_frame(c0, d, 1'b0);
        idle(1'b0, $urandom_range(16, 30));
      end else begin
        send_frame(1'b0, CPB, d, 1'b1, -1, c0);
        expect_frame(c0, d, 1'b1);
        idle(1'b0, $urandom_range(0, 20));
      end
    end
    idle(1'b0, 40);
    check_events("rand");

    idle(1'b1, 5);
    send_frame(1'b1, CPB_DEF, 8'h81, 1'b1, -1, c0);
    idle(1'b1, 40);
    chk("def_count", obs2_q.size(), 32'd1);
    if (obs2_q.size() > 0) begin
      chk("def_cycle", obs2_q[0].cyc, c0 + 2 + LAT_DEF);
      chk("def_kind", {31'd0, obs2_q[0].err}, 32'd0);
      chk("def_data", {24'd0, obs2_q[0].data}, 32'h81);
      $display("event def[0]: cycle=%0d err=%0b data=%02h", obs2_q[0].cyc, obs2_q[0].err, obs2_q[0].data);
    end

    chk("never_both_pulses", {31'd0, both_seen}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
